// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, packed read ports and the
// pending scoreboard. The master drives requests and the slave is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       we0;
    logic [ADDR_W-1:0]          waddr0;
    logic [DATA_W-1:0]          wdata0;
    logic                       we1;
    logic [ADDR_W-1:0]          waddr1;
    logic [DATA_W-1:0]          wdata1;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]          rbusy;
    logic                       pend_set;
    logic [ADDR_W-1:0]          pend_addr;
    logic [ADDR_W:0]            pend_cnt;
    logic                       pend_err;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, pend_set, pend_addr,
        input  rdata, rbusy, pend_cnt, pend_err
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, pend_set, pend_addr,
        output rdata, rbusy, pend_cnt, pend_err
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: ALU writeback on port 0 and long-latency writeback on port 1,
// optional same-cycle bypass, and a per-register pending scoreboard with a population count.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              set_eff;
    logic              cnt_inc;
    logic              cnt_dec;

    logic [ADDR_W-1:0] ra;
    logic              zero_hit, hit0, hit1;

    always_comb begin
        mem_d = mem_q;
        if (bus.we0 && !(ZERO_REG != 0 && bus.waddr0 == '0))
            mem_d[bus.waddr0] = bus.wdata0;
        // Port 1 is applied last so it wins a same-address collision.
        if (bus.we1 && !(ZERO_REG != 0 && bus.waddr1 == '0))
            mem_d[bus.waddr1] = bus.wdata1;

        set_eff = bus.pend_set && !(ZERO_REG != 0 && bus.pend_addr == '0);

        pend_d = pend_q;
        if (bus.we1)
            pend_d[bus.waddr1] = 1'b0;
        if (set_eff)
            pend_d[bus.pend_addr] = 1'b1;

        // Count deltas use the old vector; a set on the cleared address cancels the clear.
        cnt_inc = set_eff && !pend_q[bus.pend_addr];
        cnt_dec = bus.we1 && pend_q[bus.waddr1] && !(set_eff && bus.pend_addr == bus.waddr1);
        cnt_d   = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

        err_d = err_q | (set_eff && pend_q[bus.pend_addr]
                         && !(bus.we1 && bus.waddr1 == bus.pend_addr));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        ra        = '0;
        zero_hit  = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra       = bus.raddr[k*ADDR_W +: ADDR_W];
            zero_hit = (ZERO_REG != 0) && (ra == '0);
            hit1     = (BYPASS != 0) && bus.we1 && (bus.waddr1 == ra);
            hit0     = (BYPASS != 0) && bus.we0 && (bus.waddr0 == ra);
            if (reset || zero_hit) begin
                bus.rdata[k*DATA_W +: DATA_W] = '0;
                bus.rbusy[k]                  = 1'b0;
            end else if (hit1) begin
                bus.rdata[k*DATA_W +: DATA_W] = bus.wdata1;
                bus.rbusy[k]                  = 1'b0;
            end else if (hit0) begin
                bus.rdata[k*DATA_W +: DATA_W] = bus.wdata0;
                bus.rbusy[k]                  = pend_q[ra];
            end else begin
                bus.rdata[k*DATA_W +: DATA_W] = mem_q[ra];
                bus.rbusy[k]                  = pend_q[ra];
            end
        end
    end

    assign bus.pend_cnt = cnt_q;
    assign bus.pend_err = err_q;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the successor to the current single-write-port 32x32 file. Supports a configurable number of combinational read ports and two write ports. Port 0 carries single-cycle ALU writeback and port 1 carries long-latency (MUL/DIV/memory) writeback. It also provides optional same-cycle write-to-read bypass and a per-register pending scoreboard that the control FSM uses to stall on outstanding long-latency results.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns array contents only
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and pending sets

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (long-latency writeback; clears pending)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, combinational; port k occupies bits [k*DATA_W +: DATA_W]
- rbusy  out  NUM_RD  1 = register addressed by read port k has a pending long-latency result
- pend_set  in  1  mark pend_addr as awaiting port-1 writeback
- pend_addr  in  ADDR_W  scoreboard address
- pend_cnt  out  ADDR_W+1  number of registers currently pending
- pend_err  out  1  sticky flag: pend_set hit an already-pending register

## Operation
- Storage: 2^ADDR_W x DATA_W array, plus a 2^ADDR_W-bit pending vector.
- Reset (async): all registers = 0, pending = 0, pend_cnt = 0, pend_err = 0. While reset is high, rdata = 0 and rbusy = 0 regardless of raddr, bypass and we inputs.
- Write: on a clock edge, each enabled port writes its data to its address.
  - Both ports enabled to the same address: port 1 wins.
  - ZERO_REG=1 and address 0: the write is discarded.
- Read port k, in priority order:
  - ZERO_REG=1 and raddr_k = 0 -> 0.
  - BYPASS=1 and we1 with waddr1 = raddr_k -> wdata1.
  - BYPASS=1 and we0 with waddr0 = raddr_k -> wdata0.
  - Otherwise -> array[raddr_k].
- Scoreboard:
  - pend_set sets pending[pend_addr] at the clock edge.
  - we1 clears pending[waddr1] at the clock edge. Port 0 writes never touch pending.
  - pend_set and we1 to the same address in the same cycle: set wins; the register stays pending and wdata1 is still written.
  - ZERO_REG=1: pend_set to address 0 is ignored.
  - pend_set to an address already pending (and not cleared the same cycle) sets pend_err. pend_err clears only on reset.
- rbusy_k = pending[raddr_k], except:
  - BYPASS=1 with we1 and waddr1 = raddr_k this cycle -> 0, because the data is forwarded.
  - ZERO_REG=1 with raddr_k = 0 -> 0.
- pend_cnt is a registered population count of the pending vector, updated each edge: +1 on an effective set, -1 on an effective clear of a pending bit, net 0 when both occur on different addresses. It never wraps; the maximum value is 2^ADDR_W.

## Timing
- Read latency 0: rdata and rbusy are combinational from raddr, array state and (if BYPASS) the current write inputs.
- Write latency 1: array contents are updated at the edge. Without bypass, the new value is visible on the read ports in the cycle after the edge.
- Pending set and clear take effect at the edge. rbusy reflects a new set from the next cycle onward.
- Reset deassertion is synchronised externally. The first write accepted is at the first rising edge with reset low.
- Reset mid-operation: state clears immediately. Writes in flight during that cycle are lost.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via port 0; next cycle raddr0=5 -> rdata0=0xDEADBEEF. Before the edge with BYPASS=1 -> 0xDEADBEEF; with BYPASS=0 -> 0x00000000.
- we0 (r7, 0x11111111) and we1 (r7, 0x22222222) in the same cycle -> r7 = 0x22222222. Same-cycle bypass read of r7 returns 0x22222222.
- ZERO_REG=1: we0 to r0 with 0xFFFFFFFF, pend_set r0 -> rdata for r0 = 0, rbusy = 0, pend_cnt = 0.
- pend_set r3 -> next cycle rbusy for r3 = 1 and pend_cnt = 1. we1 r3 = 0x1234 -> that cycle rbusy = 0 (BYPASS=1) and rdata = 0x1234; next cycle pend_cnt = 0.
- pend_set r4 twice without an intervening writeback -> pend_err = 1 and pend_cnt = 1. Same-cycle pend_set r9 + we1 r9 -> r9 stays pending and pend_err is unchanged.
- Assert reset asynchronously mid-cycle after filling r1..r31 and 5 pending -> rdata = 0, rbusy = 0, pend_cnt = 0 and pend_err = 0 immediately. After release, all registers read 0.
